// File: rtl/jk_flip_flop.sv
`default_nettype none
// ============================================================================
// Module      : jk_flip_flop
// Description : Bank of WIDTH independent, positive-edge-triggered JK
//               flip-flops with complementary outputs. Asynchronous,
//               active-high reset loads RESET_VALUE into Q.
//
//               Optional feature macro: JK_FLIP_FLOP_CE_EN
//                 defined   -> adds input ce; an edge with ce=0 holds every bit
//                 undefined -> no ce port; every rising edge is active
//
// Ports       : Q      out WIDTH  registered flip-flop state
//               Q_bar  out WIDTH  bitwise complement of Q
//               J      in  WIDTH  per-bit set input
//               K      in  WIDTH  per-bit reset input
//               clk    in  1      clock, rising-edge active
//               reset  in  1      asynchronous active-high reset
//               ce     in  1      clock enable (JK_FLIP_FLOP_CE_EN only)
//
// Revision    : 1.0  initial release
// ============================================================================
module jk_flip_flop #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_bar,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    input  logic             clk,
    input  logic             reset
`ifdef JK_FLIP_FLOP_CE_EN
    ,
    input  logic             ce
`endif
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_jk;
    logic [WIDTH-1:0] w_q_next;
    logic             w_enable;

`ifdef JK_FLIP_FLOP_CE_EN
    assign w_enable = ce;
`else
    assign w_enable = 1'b1;
`endif

    // Characteristic equation Q+ = J&~Q | ~K&Q, evaluated independently per
    // bit. Written as logic rather than a case on {J,K} so that an X/Z on J
    // or K propagates into Q instead of silently selecting a default branch.
    assign w_q_jk   = (J & ~r_q) | (~K & r_q);
    assign w_q_next = w_enable ? w_q_jk : r_q;

    // Reset dominates: while reset is high every rising edge is ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= RESET_VALUE;
        end else begin
            r_q <= w_q_next;
        end
    end

    // Q_bar has no state of its own; it is always the complement of Q.
    assign Q     = r_q;
    assign Q_bar = ~r_q;

endmodule
`default_nettype wire

// File: tb/tb_jk_flip_flop.sv
`default_nettype none
// ============================================================================
// Module      : tb_jk_flip_flop
// Description : Self-checking bench for jk_flip_flop (WIDTH=1). Expected Q
//               values are pushed to a scoreboard queue when J/K are driven
//               and popped when Q is sampled one time unit after the edge.
// Revision    : 1.0  initial release
// ============================================================================
module tb_jk_flip_flop;

    logic clk;
    logic reset;
    logic J;
    logic K;
    logic Q;
    logic Q_bar;
    logic r_ce;

    int   n_checks;
    int   n_errors;
    logic r_model_q;
    logic sb_q[$];

    jk_flip_flop #(
        .WIDTH       (1),
        .RESET_VALUE (1'b0)
    ) u_dut (
        .Q     (Q),
        .Q_bar (Q_bar),
        .J     (J),
        .K     (K),
        .clk   (clk),
        .reset (reset)
`ifdef JK_FLIP_FLOP_CE_EN
        ,
        .ce    (r_ce)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic check_value(input string tag, input logic obs, input logic exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference JK truth table.
    function automatic logic jk_model(input logic q, input logic j, input logic k);
        case ({j, k})
            2'b00:   return q;
            2'b01:   return 1'b0;
            2'b10:   return 1'b1;
            default: return ~q;
        endcase
    endfunction

    // Drive J/K away from the edge, push the expectation, then sample
    // one time unit after the next rising edge and compare.
    task automatic drive_edge(input string tag, input logic j, input logic k);
        logic exp;
        J = j;
        K = k;
        if (r_ce) r_model_q = jk_model(r_model_q, j, k);
        sb_q.push_back(r_model_q);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_value({tag, "_sb_empty"}, 1'b1, 1'b0);
        end else begin
            exp = sb_q.pop_front();
            check_value({tag, "_q"}, Q, exp);
            check_value({tag, "_qbar"}, Q_bar, ~exp);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        r_ce      = 1'b1;
        reset     = 1'b1;
        J         = 1'b0;
        K         = 1'b0;
        r_model_q = 1'b0;

        // 1: reset from t=0 forces Q=0 without a clock edge
        #1;
        check_value("reset_q", Q, 1'b0);
        check_value("reset_qbar", Q_bar, 1'b1);
        // set J=1 so an edge not ignored under reset would be visible
        #1;
        J = 1'b1;
        @(posedge clk);
        #1;
        check_value("reset_edge_ignored", Q, 1'b0);
        J = 1'b0;
        #1;
        reset = 1'b0;

        // 2: hold then set
        drive_edge("hold0", 1'b0, 1'b0);
        drive_edge("set", 1'b1, 1'b0);
        // 3: clear then hold
        drive_edge("clear", 1'b0, 1'b1);
        drive_edge("hold_after_clear", 1'b0, 1'b0);
        // 4: toggle four times from Q=0
        for (int i = 0; i < 4; i++) drive_edge("toggle", 1'b1, 1'b1);

        // 5: asynchronous reset pulse mid-cycle, then toggle
        drive_edge("set_before_rst", 1'b1, 1'b0);
        #4;
        reset = 1'b1;
        #1;
        check_value("async_rst_q", Q, 1'b0);
        check_value("async_rst_qbar", Q_bar, 1'b1);
        #2;
        reset = 1'b0;
        r_model_q = 1'b0;
        drive_edge("toggle_after_rst", 1'b1, 1'b1);

        // 6: repeated J/K sweep 00,01,10,11
        for (int i = 0; i < 16; i++) begin
            logic [1:0] v;
            v = 2'(i % 4);
            drive_edge("sweep", v[1], v[0]);
        end
        // random J/K
        for (int i = 0; i < 16; i++) begin
            drive_edge("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

`ifdef JK_FLIP_FLOP_CE_EN
        // ce=0 freezes Q regardless of J/K; reset still acts asynchronously
        drive_edge("ce_pre_set", 1'b1, 1'b0);
        r_ce = 1'b0;
        for (int i = 0; i < 8; i++) begin
            logic [1:0] v;
            v = 2'(i % 4);
            drive_edge("ce_off", v[1], v[0]);
        end
        reset = 1'b1;
        #1;
        check_value("ce_off_async_rst", Q, 1'b0);
        reset = 1'b0;
        r_model_q = 1'b0;
        drive_edge("ce_off_after_rst", 1'b1, 1'b0);
        r_ce = 1'b1;
        drive_edge("ce_on_again", 1'b1, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
